// File: rtl/ys_poly_small_stream.sv
// ys_poly_small_stream: streaming pass/difference/scale of polynomial coefficients
module ys_poly_small_stream #(
  parameter int CW    = 13,
  parameter int LANES = 4,
  parameter int N     = 701
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW*LANES-1:0] din_a,
  input  logic [CW*LANES-1:0] din_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW*LANES-1:0] dout_a,
  output logic [CW*LANES-1:0] dout_b,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int BEATS = (N + 2*LANES - 1) / (2*LANES);
  localparam int CNTW = $clog2(BEATS + 1);
  localparam logic [CNTW-1:0] C_BEATS = CNTW'(BEATS);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(BEATS - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0] r_carry;
  logic [1:0] r_mode;
  logic r_out_valid, r_out_last, r_done;
  logic [CW*LANES-1:0] r_dout_a, r_dout_b, w_ya, w_yb;
  logic [CW-1:0] w_x [2*LANES];
  logic [CW-1:0] w_p [2*LANES];
  logic [CW-1:0] w_d [2*LANES];
  logic [CW-1:0] w_y [2*LANES];
  logic w_start, w_in_acc, w_out_acc, w_last_acc;

  assign w_start    = start & (r_state == IDLE);
  assign in_ready   = (r_state == RUN) & (r_cnt < C_BEATS) & (!r_out_valid | out_ready);
  assign w_in_acc   = in_valid & in_ready;
  assign w_out_acc  = r_out_valid & out_ready;
  assign w_last_acc = (r_state == RUN) & w_out_acc & r_out_last;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign dout_a     = r_dout_a;
  assign dout_b     = r_dout_b;
  assign busy       = (r_state == RUN);
  assign done       = r_done;

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // Next state: enter RUN on start, leave once the last result beat is taken
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = RUN;
    else if (w_last_acc) w_state_nxt = IDLE;
  end

  // Per-lane result; lane 0's predecessor is the carried top lane of the previous beat
  always_comb begin
    w_ya = '0;
    w_yb = '0;
    for (int k = 0; k < LANES; k++) begin
      w_x[k] = din_a[CW*k +: CW];
      w_x[k+LANES] = din_b[CW*k +: CW];
    end
    w_p[0] = r_carry;
    for (int k = 1; k < 2*LANES; k++) w_p[k] = w_x[k-1];
    for (int k = 0; k < 2*LANES; k++) begin
      w_d[k] = w_p[k] - w_x[k];
      w_y[k] = (r_mode == 2'd0) ? w_x[k] :
               (r_mode == 2'd1) ? w_d[k] :
               (r_mode == 2'd2) ? (w_d[k] << 1) + w_d[k] : (w_x[k] << 1) + w_x[k];
      if (int'(r_cnt) * 2 * LANES + k >= N) w_y[k] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      w_ya[CW*k +: CW] = w_y[k];
      w_yb[CW*k +: CW] = w_y[k+LANES];
    end
  end

  // Pass bookkeeping, carry and the single-entry output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_carry <= '0;
      r_mode <= '0;
      r_out_valid <= 1'b0;
      r_out_last <= 1'b0;
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
        r_carry <= '0;
        r_mode <= mode;
      end
      if (w_in_acc) begin
        r_cnt <= r_cnt + 1'b1;
        r_carry <= w_x[2*LANES-1];
        r_dout_a <= w_ya;
        r_dout_b <= w_yb;
        r_out_valid <= 1'b1;
        r_out_last <= (r_cnt == C_LAST);
      end else if (w_out_acc) begin
        r_out_valid <= 1'b0;
        r_out_last <= 1'b0;
      end
      r_done <= w_last_acc;
    end
endmodule

// File: tb/tb_ys_poly_small_stream.sv
// tb_ys_poly_small_stream: vector table, directed corner cases and random passes vs a flat model
module tb_ys_poly_small_stream;
  localparam int CW = 13, LANES = 4, N = 20, BEATS = 3, TOT = 24;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [1:0] mode = 0;
  logic [CW*LANES-1:0] din_a = '0, din_b = '0;
  logic in_ready, out_valid, out_last, busy, done;
  logic [CW*LANES-1:0] dout_a, dout_b;
  logic [CW-1:0] xs [TOT];
  logic [CW-1:0] got [TOT];
  logic [CW-1:0] ex [TOT];
  int checks = 0, errors = 0;

  ys_poly_small_stream #(.CW(CW), .LANES(LANES), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .din_a(din_a), .din_b(din_b), .out_valid(out_valid), .out_ready(out_ready),
    .dout_a(dout_a), .dout_b(dout_b), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] m; int pat; int idx; logic [CW-1:0] exp;} vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic fill_pat(input int p);
    for (int i = 0; i < TOT; i++)
      xs[i] = (p == 0) ? CW'(i) : (i == 0) ? CW'(5) : (i == 7) ? CW'(1) : (i >= N) ? CW'(99) : '0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < TOT; i++) xs[i] = CW'($urandom);
  endtask

  // Flat reference: y[i] from x[i-1] and x[i] over the whole sequence, wrapped to CW bits
  task automatic model(input logic [1:0] m);
    int p, x, y;
    for (int i = 0; i < TOT; i++) begin
      p = (i == 0) ? 0 : int'(xs[i-1]);
      x = int'(xs[i]);
      y = (m == 0) ? x : (m == 1) ? p - x : (m == 2) ? 3 * (p - x) : 3 * x;
      ex[i] = (i >= N) ? '0 : CW'(y & ((1 << CW) - 1));
    end
  endtask

  task automatic compare(input string name);
    for (int i = 0; i < TOT; i++) chk($sformatf("%s y[%0d]", name, i), got[i], ex[i]);
  endtask

  task automatic pack(input int b);
    din_a = '0;
    din_b = '0;
    if (b < BEATS)
      for (int k = 0; k < LANES; k++) begin
        din_a[CW*k +: CW] = xs[2*LANES*b + k];
        din_b[CW*k +: CW] = xs[2*LANES*b + LANES + k];
      end
  endtask

  // bp: 0 full rate, 1 random handshakes, 2 three-cycle stall on the first result beat
  task automatic run_pass(input logic [1:0] m, input int bp, input bit restart);
    int n_in, n_out, stall;
    bit hold, prev_acc, fin, tput_bad;
    logic [CW*LANES-1:0] ha, hb;
    for (int i = 0; i < TOT; i++) got[i] = 13'h1555;
    start = 1;
    mode = m;
    @(posedge clk); #1;
    start = 0;
    chk("busy after start", busy, 1);
    n_in = 0; n_out = 0; stall = 0; hold = 0; prev_acc = 0; fin = 0; tput_bad = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      in_valid = (n_in < BEATS) && (bp == 1 ? $urandom_range(0, 1) == 1 : 1'b1);
      out_ready = (bp == 1) ? $urandom_range(0, 1) == 1 : 1'b1;
      if (bp == 2 && out_valid && stall < 3) begin out_ready = 0; stall++; end
      start = restart && cyc == 1;
      mode = (restart && cyc == 1) ? ~m : m;
      pack(n_in);
      @(negedge clk);
      if (prev_acc) chk("latency out_valid", out_valid, 1);
      if (hold) chk("hold dout", {dout_a, dout_b}, {ha, hb});
      hold = out_valid && !out_ready;
      if (hold) begin
        chk("in_ready under stall", in_ready, 0);
        ha = dout_a;
        hb = dout_b;
      end
      if (bp == 0 && n_in < BEATS && !in_ready) tput_bad = 1;
      prev_acc = in_valid && in_ready;
      if (prev_acc) n_in++;
      if (out_valid && out_ready && n_out < BEATS) begin
        for (int k = 0; k < LANES; k++) begin
          got[2*LANES*n_out + k] = dout_a[CW*k +: CW];
          got[2*LANES*n_out + LANES + k] = dout_b[CW*k +: CW];
        end
        chk("out_last", out_last, n_out == BEATS - 1);
        if (out_last) fin = 1;
        n_out++;
      end
      @(posedge clk); #1;
    end
    start = 0;
    in_valid = 0;
    out_ready = 0;
    if (!fin) chk("pass timeout", 0, 1);
    chk("done after last", done, 1);
    chk("idle after last", busy, 0);
    if (bp == 0) chk("no bubble", tput_bad, 0);
    if (bp == 2) chk("stall count", stall, 3);
    @(posedge clk); #1;
    chk("done one cycle", done, 0);
  endtask

  initial begin
    tbl[0]  = '{2'd2, 0, 0, 13'd0};
    tbl[1]  = '{2'd2, 0, 1, 13'd8189};
    tbl[2]  = '{2'd2, 0, 15, 13'd8189};
    tbl[3]  = '{2'd2, 1, 0, 13'd8177};
    tbl[4]  = '{2'd2, 1, 1, 13'd15};
    tbl[5]  = '{2'd2, 1, 8, 13'd3};
    tbl[6]  = '{2'd2, 1, 2, 13'd0};
    tbl[7]  = '{2'd1, 0, 5, 13'd8191};
    tbl[8]  = '{2'd0, 0, 13, 13'd13};
    tbl[9]  = '{2'd3, 0, 19, 13'd57};
    tbl[10] = '{2'd3, 0, 21, 13'd0};
    tbl[11] = '{2'd0, 1, 22, 13'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset dout", {dout_a, dout_b}, 0);
    chk("reset done", done, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      fill_pat(tbl[t].pat);
      run_pass(tbl[t].m, 0, 0);
      chk($sformatf("tbl%0d y[%0d]", t, tbl[t].idx), got[tbl[t].idx], tbl[t].exp);
    end

    fill_pat(0);
    run_pass(2'd2, 2, 0);
    model(2'd2);
    compare("stall");

    fill_rand();
    run_pass(2'd2, 0, 1);
    model(2'd2);
    compare("restart ignored");

    fill_rand();
    start = 1;
    mode = 2'd2;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    out_ready = 1;
    for (int b = 0; b < 2; b++) begin
      pack(b);
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_last", out_last, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst dout", {dout_a, dout_b}, 0);
    chk("midrst done", done, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("no resume", busy, 0);
    fill_rand();
    run_pass(2'd1, 1, 0);
    model(2'd1);
    compare("after reset");

    for (int r = 0; r < 8; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      fill_rand();
      run_pass(m, 1, 0);
      model(m);
      compare($sformatf("rand%0d m%0d", r, m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
